// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types for the raster generator and the
// picture stage that consumes its scan position.
package vga_timing_pkg;

   // Coordinate width; every supported raster fits in 2048 columns/rows.
   localparam int COORD_W     = 11;
   localparam int FRAME_CNT_W = 16;

   // Default timing for the 50 MHz 1040 x 666 display path.
   localparam int DEFAULT_H_TOTAL      = 1040;
   localparam int DEFAULT_H_ACTIVE     = 900;
   localparam int DEFAULT_H_SYNC_START = 919;
   localparam int DEFAULT_H_SYNC_END   = 1039;
   localparam int DEFAULT_V_TOTAL      = 666;
   localparam int DEFAULT_V_ACTIVE     = 650;
   localparam int DEFAULT_V_SYNC_START = 659;
   localparam int DEFAULT_V_SYNC_END   = 665;
   localparam int DEFAULT_TICK_CYCLES  = 12_500_000;
   localparam int DEFAULT_PIPE_DELAY   = 1;

   typedef logic [COORD_W-1:0]     coord_t;
   typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

   // The three level signals that travel down the sync delay line together.
   typedef struct packed {
      logic hsync_n;
      logic vsync_n;
      logic de;
   } sync_bus_t;

   // Idle level of the sync bus: both syncs deasserted, outside active area.
   localparam logic [2:0] SYNC_RESET_BITS = 3'b110;

   // Width of the animation tick counter; never narrower than one bit.
   function automatic int tickWidth(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the picture stage.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   coord_t     col;
   coord_t     row;
   logic       hsync_n;
   logic       vsync_n;
   logic       de;
   logic       line_start;
   logic       frame_start;
   logic       anim_tick;
   logic       anim_phase;
   frame_cnt_t frame_cnt;
   logic       hsync_n_d;
   logic       vsync_n_d;
   logic       de_d;

   modport master (
      output col, row, hsync_n, vsync_n, de, line_start, frame_start,
             anim_tick, anim_phase, frame_cnt, hsync_n_d, vsync_n_d, de_d
   );

   modport slave (
      input  col, row, hsync_n, vsync_n, de, line_start, frame_start,
             anim_tick, anim_phase, frame_cnt, hsync_n_d, vsync_n_d, de_d
   );

endinterface

// File: rtl/sync_delay_line.sv
// Resettable shift register of configurable depth. Depth zero is a plain
// wire, so callers can line up sync signals with a pipeline of any length.
module sync_delay_line #(
   parameter int               DEPTH       = 1,
   parameter int               WIDTH       = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_pass
      // With no stages the clock and reset have nothing to drive.
      logic unusedClockReset;
      assign unusedClockReset = CLK ^ rst;
      assign q = d;
   end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      // Every stage loads the idle pattern on reset so the delayed copies
      // show inactive levels until real data has propagated through.
      always_ff @(posedge CLK) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
               stages[i] <= RESET_VALUE;
            end
         end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
               stages[i] <= stages[i-1];
            end
         end
      end

      assign q = stages[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: scan position, sync pulses,
// data enable, line/frame markers, a frame-aligned animation tick and sync
// copies delayed to match the downstream registered RGB output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL      = DEFAULT_H_TOTAL,
   parameter int H_ACTIVE     = DEFAULT_H_ACTIVE,
   parameter int H_SYNC_START = DEFAULT_H_SYNC_START,
   parameter int H_SYNC_END   = DEFAULT_H_SYNC_END,
   parameter int V_TOTAL      = DEFAULT_V_TOTAL,
   parameter int V_ACTIVE     = DEFAULT_V_ACTIVE,
   parameter int V_SYNC_START = DEFAULT_V_SYNC_START,
   parameter int V_SYNC_END   = DEFAULT_V_SYNC_END,
   parameter int TICK_CYCLES  = DEFAULT_TICK_CYCLES,
   parameter int PIPE_DELAY   = DEFAULT_PIPE_DELAY
) (
   input logic              CLK,
   input logic              rst,
   vga_timing_gen_if.master vga
);

   // One extra bit so bounds equal to 2048 still compare correctly.
   typedef logic [COORD_W:0] ext_t;

   localparam int TC_W = tickWidth(TICK_CYCLES);

   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
   localparam ext_t   H_ACT  = ext_t'(H_ACTIVE);
   localparam ext_t   H_SS   = ext_t'(H_SYNC_START);
   localparam ext_t   H_SE   = ext_t'(H_SYNC_END);
   localparam ext_t   V_ACT  = ext_t'(V_ACTIVE);
   localparam ext_t   V_SS   = ext_t'(V_SYNC_START);
   localparam ext_t   V_SE   = ext_t'(V_SYNC_END);

   localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_CYCLES - 1);

   // Reject geometries the counters or decode cannot represent.
   if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_err_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
   end
   if (H_SYNC_END <= H_SYNC_START || V_SYNC_END <= V_SYNC_START) begin : g_err_sync_order
      $error("vga_timing_gen: sync end must be after sync start");
   end
   if (H_SYNC_START < H_ACTIVE || V_SYNC_START < V_ACTIVE) begin : g_err_sync_overlap
      $error("vga_timing_gen: sync window overlaps the active area");
   end
   if (H_SYNC_END > H_TOTAL || V_SYNC_END > V_TOTAL) begin : g_err_sync_range
      $error("vga_timing_gen: sync window extends past the line or frame");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_err_delay
      $error("vga_timing_gen: PIPE_DELAY must be within 0..8");
   end
   if (TICK_CYCLES < 1) begin : g_err_tick
      $error("vga_timing_gen: TICK_CYCLES must be at least 1");
   end

   coord_t          hc;
   coord_t          vc;
   logic [TC_W-1:0] tc;
   logic            pending;

   coord_t     colQ;
   coord_t     rowQ;
   logic       hsyncNQ;
   logic       vsyncNQ;
   logic       deQ;
   logic       lineStartQ;
   logic       frameStartQ;
   logic       animTickQ;
   logic       animPhaseQ;
   frame_cnt_t frameCntQ;

   sync_bus_t  syncNow;
   sync_bus_t  syncDelayed;

   logic hcWrap;
   logic vcWrap;
   logic tcWrap;
   logic lineStartNow;
   logic frameStartNow;
   logic fireTick;
   logic hsyncActive;
   logic vsyncActive;
   logic activeArea;

   assign hcWrap        = (hc == H_LAST);
   assign vcWrap        = (vc == V_LAST);
   assign tcWrap        = (tc == TC_LAST);
   assign lineStartNow  = (hc == '0);
   assign frameStartNow = lineStartNow && (vc == '0);
   assign fireTick      = frameStartNow && (pending || tcWrap);
   assign hsyncActive   = ({1'b0, hc} >= H_SS) && ({1'b0, hc} < H_SE);
   assign vsyncActive   = ({1'b0, vc} >= V_SS) && ({1'b0, vc} < V_SE);
   assign activeArea    = ({1'b0, hc} < H_ACT) && ({1'b0, vc} < V_ACT);

   // Raster scan counters: the column runs every clock and the row steps
   // whenever the column wraps, so (0,0) is the first pixel of each frame.
   always_ff @(posedge CLK) begin
      if (rst) begin
         hc <= '0;
         vc <= '0;
      end else if (hcWrap) begin
         hc <= '0;
         vc <= vcWrap ? '0 : vc + 1'b1;
      end else begin
         hc <= hc + 1'b1;
      end
   end

   // Animation interval timer. A wrap only requests a tick; the request is
   // held until the next frame start so motion never tears mid-frame, and
   // a wrap landing on a frame start is consumed immediately instead.
   always_ff @(posedge CLK) begin
      if (rst) begin
         tc      <= '0;
         pending <= 1'b0;
      end else begin
         tc <= tcWrap ? '0 : tc + 1'b1;
         if (frameStartNow) begin
            pending <= 1'b0;
         end else if (tcWrap) begin
            pending <= 1'b1;
         end
      end
   end

   // All outputs are decoded from the same counter snapshot and registered
   // together, so downstream logic sees them aligned on one clock.
   always_ff @(posedge CLK) begin
      if (rst) begin
         colQ        <= '0;
         rowQ        <= '0;
         hsyncNQ     <= 1'b1;
         vsyncNQ     <= 1'b1;
         deQ         <= 1'b0;
         lineStartQ  <= 1'b0;
         frameStartQ <= 1'b0;
         animTickQ   <= 1'b0;
         animPhaseQ  <= 1'b0;
         frameCntQ   <= '0;
      end else begin
         colQ        <= hc;
         rowQ        <= vc;
         hsyncNQ     <= ~hsyncActive;
         vsyncNQ     <= ~vsyncActive;
         deQ         <= activeArea;
         lineStartQ  <= lineStartNow;
         frameStartQ <= frameStartNow;
         animTickQ   <= fireTick;
         if (fireTick) begin
            animPhaseQ <= ~animPhaseQ;
         end
         if (frameStartNow) begin
            frameCntQ <= frameCntQ + 1'b1;
         end
      end
   end

   assign syncNow = '{hsync_n: hsyncNQ, vsync_n: vsyncNQ, de: deQ};

   sync_delay_line #(
      .DEPTH       (PIPE_DELAY),
      .WIDTH       (3),
      .RESET_VALUE (SYNC_RESET_BITS)
   ) u_sync_delay (
      .CLK (CLK),
      .rst (rst),
      .d   (syncNow),
      .q   (syncDelayed)
   );

   assign vga.col         = colQ;
   assign vga.row         = rowQ;
   assign vga.hsync_n     = hsyncNQ;
   assign vga.vsync_n     = vsyncNQ;
   assign vga.de          = deQ;
   assign vga.line_start  = lineStartQ;
   assign vga.frame_start = frameStartQ;
   assign vga.anim_tick   = animTickQ;
   assign vga.anim_phase  = animPhaseQ;
   assign vga.frame_cnt   = frameCntQ;
   assign vga.hsync_n_d   = syncDelayed.hsync_n;
   assign vga.vsync_n_d   = syncDelayed.vsync_n;
   assign vga.de_d        = syncDelayed.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken 20 x 8 raster so
// several whole frames fit in a short run. Two instances differ in tick
// interval and sync delay depth.
module tb_vga_timing_gen;

   localparam int H_TOTAL   = 20;
   localparam int H_ACTIVE  = 12;
   localparam int H_SS      = 14;
   localparam int H_SE      = 18;
   localparam int V_TOTAL   = 8;
   localparam int V_ACTIVE  = 5;
   localparam int V_SS      = 6;
   localparam int V_SE      = 7;
   localparam int FRAME     = H_TOTAL * V_TOTAL;
   localparam int TICK_A    = 161;
   localparam int DELAY_A   = 2;
   localparam int TICK_B    = 50;
   localparam int DELAY_B   = 0;
   localparam int NUM_VECS  = 16;

   typedef struct packed {
      logic [10:0] col;
      logic [10:0] row;
      logic        hsyncN;
      logic        vsyncN;
      logic        de;
      logic        lineStart;
      logic        frameStart;
      logic        animTick;
      logic        animPhase;
      logic [15:0] frameCnt;
      logic        hsyncNd;
      logic        vsyncNd;
      logic        deD;
   } obs_t;

   typedef struct {
      int          cycle;
      logic [10:0] col;
      logic [10:0] row;
      logic        hs;
      logic        vs;
      logic        de;
      logic        ls;
      logic        fs;
      logic [15:0] fcnt;
   } vec_t;

   localparam obs_t RESET_OBS = '{col: 11'd0, row: 11'd0, hsyncN: 1'b1,
      vsyncN: 1'b1, de: 1'b0, lineStart: 1'b0, frameStart: 1'b0,
      animTick: 1'b0, animPhase: 1'b0, frameCnt: 16'd0,
      hsyncNd: 1'b1, vsyncNd: 1'b1, deD: 1'b0};

   logic CLK = 1'b0;
   logic rst;

   int   errors;
   int   checks;
   int   modelN;
   int   curN;

   obs_t qA[$];
   obs_t qB[$];
   obs_t actA;
   obs_t actB;
   obs_t expA;
   obs_t expB;
   vec_t vecs[NUM_VECS];

   vga_timing_gen_if ifA ();
   vga_timing_gen_if ifB ();

   vga_timing_gen #(
      .H_TOTAL (H_TOTAL), .H_ACTIVE (H_ACTIVE), .H_SYNC_START (H_SS), .H_SYNC_END (H_SE),
      .V_TOTAL (V_TOTAL), .V_ACTIVE (V_ACTIVE), .V_SYNC_START (V_SS), .V_SYNC_END (V_SE),
      .TICK_CYCLES (TICK_A), .PIPE_DELAY (DELAY_A)
   ) dutA (
      .CLK (CLK),
      .rst (rst),
      .vga (ifA)
   );

   vga_timing_gen #(
      .H_TOTAL (H_TOTAL), .H_ACTIVE (H_ACTIVE), .H_SYNC_START (H_SS), .H_SYNC_END (H_SE),
      .V_TOTAL (V_TOTAL), .V_ACTIVE (V_ACTIVE), .V_SYNC_START (V_SS), .V_SYNC_END (V_SE),
      .TICK_CYCLES (TICK_B), .PIPE_DELAY (DELAY_B)
   ) dutB (
      .CLK (CLK),
      .rst (rst),
      .vga (ifB)
   );

   always #5 CLK = ~CLK;

   assign actA = {ifA.col, ifA.row, ifA.hsync_n, ifA.vsync_n, ifA.de, ifA.line_start,
                  ifA.frame_start, ifA.anim_tick, ifA.anim_phase, ifA.frame_cnt,
                  ifA.hsync_n_d, ifA.vsync_n_d, ifA.de_d};
   assign actB = {ifB.col, ifB.row, ifB.hsync_n, ifB.vsync_n, ifB.de, ifB.line_start,
                  ifB.frame_start, ifB.anim_tick, ifB.anim_phase, ifB.frame_cnt,
                  ifB.hsync_n_d, ifB.vsync_n_d, ifB.de_d};

   // Number of interval-timer wraps at or before cycle x after release.
   function automatic int wrapsUpTo(input int x, input int tick);
      if (x < 0) return 0;
      return (x + 1) / tick;
   endfunction

   // A frame fires a tick when any wrap fell after the previous frame start
   // and no later than this one.
   function automatic bit tickAtFrame(input int k, input int tick);
      return wrapsUpTo(k * FRAME, tick) > wrapsUpTo(k * FRAME - FRAME, tick);
   endfunction

   function automatic obs_t baseObs(input int n, input int tick);
      obs_t o;
      int   c;
      int   r;
      int   k;
      int   ticks;
      c = n % H_TOTAL;
      r = (n / H_TOTAL) % V_TOTAL;
      k = n / FRAME;
      ticks = 0;
      for (int j = 0; j <= k; j++) begin
         if (tickAtFrame(j, tick)) ticks++;
      end
      o = RESET_OBS;
      o.col        = 11'(c);
      o.row        = 11'(r);
      o.hsyncN     = !(c >= H_SS && c < H_SE);
      o.vsyncN     = !(r >= V_SS && r < V_SE);
      o.de         = (c < H_ACTIVE) && (r < V_ACTIVE);
      o.lineStart  = (c == 0);
      o.frameStart = (c == 0) && (r == 0);
      o.animTick   = o.frameStart && tickAtFrame(k, tick);
      o.animPhase  = ticks[0];
      o.frameCnt   = 16'(k + 1);
      return o;
   endfunction

   function automatic obs_t expObs(input int n, input int tick, input int delay);
      obs_t o;
      obs_t d;
      o = baseObs(n, tick);
      if (n - delay >= 0) begin
         d = baseObs(n - delay, tick);
         o.hsyncNd = d.hsyncN;
         o.vsyncNd = d.vsyncN;
         o.deD     = d.de;
      end else begin
         o.hsyncNd = 1'b1;
         o.vsyncNd = 1'b1;
         o.deD     = 1'b0;
      end
      return o;
   endfunction

   function automatic vec_t mkVec(input int cyc, input int c, input int r, input bit hs,
                                  input bit vs, input bit de, input bit ls, input bit fs,
                                  input int fc);
      vec_t v;
      v.cycle = cyc;
      v.col   = 11'(c);
      v.row   = 11'(r);
      v.hs    = hs;
      v.vs    = vs;
      v.de    = de;
      v.ls    = ls;
      v.fs    = fs;
      v.fcnt  = 16'(fc);
      return v;
   endfunction

   function automatic logic [63:0] packObs(input obs_t o);
      return 64'({o.col, o.row, o.hsyncN, o.vsyncN, o.de, o.lineStart, o.frameStart, o.frameCnt});
   endfunction

   function automatic logic [63:0] packVec(input vec_t v);
      return 64'({v.col, v.row, v.hs, v.vs, v.de, v.ls, v.fs, v.fcnt});
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive reset, queue what both instances must
   // show after this edge, then step past the edge.
   task automatic applyStimulus(input logic rstVal);
      rst = rstVal;
      if (rstVal) begin
         qA.push_back(RESET_OBS);
         qB.push_back(RESET_OBS);
      end else begin
         qA.push_back(expObs(modelN, TICK_A, DELAY_A));
         qB.push_back(expObs(modelN, TICK_B, DELAY_B));
      end
      @(posedge CLK);
      #1;
      if (rstVal) begin
         curN   = -1;
         modelN = 0;
      end else begin
         curN   = modelN;
         modelN = modelN + 1;
      end
   endtask

   // Scoreboard: every edge's queued expectation is compared mid-cycle.
   always @(negedge CLK) begin
      if (qA.size() > 0) begin
         expA = qA.pop_front();
         checkOutput("scoreboard A", 64'(actA), 64'(expA));
      end
      if (qB.size() > 0) begin
         expB = qB.pop_front();
         checkOutput("scoreboard B", 64'(actB), 64'(expB));
      end
   end

   initial begin
      int hsLow;
      int vsLow;
      int deHigh;
      int gap;

      errors = 0;
      checks = 0;
      modelN = 0;
      curN   = -1;
      rst    = 1'b1;

      vecs[0]  = mkVec(0,    0, 0, 1, 1, 1, 1, 1, 1);
      vecs[1]  = mkVec(1,    1, 0, 1, 1, 1, 0, 0, 1);
      vecs[2]  = mkVec(11,  11, 0, 1, 1, 1, 0, 0, 1);
      vecs[3]  = mkVec(12,  12, 0, 1, 1, 0, 0, 0, 1);
      vecs[4]  = mkVec(13,  13, 0, 1, 1, 0, 0, 0, 1);
      vecs[5]  = mkVec(14,  14, 0, 0, 1, 0, 0, 0, 1);
      vecs[6]  = mkVec(17,  17, 0, 0, 1, 0, 0, 0, 1);
      vecs[7]  = mkVec(18,  18, 0, 1, 1, 0, 0, 0, 1);
      vecs[8]  = mkVec(19,  19, 0, 1, 1, 0, 0, 0, 1);
      vecs[9]  = mkVec(20,   0, 1, 1, 1, 1, 1, 0, 1);
      vecs[10] = mkVec(104,  4, 5, 1, 1, 0, 0, 0, 1);
      vecs[11] = mkVec(120,  0, 6, 1, 0, 0, 1, 0, 1);
      vecs[12] = mkVec(135, 15, 6, 0, 0, 0, 0, 0, 1);
      vecs[13] = mkVec(140,  0, 7, 1, 1, 0, 1, 0, 1);
      vecs[14] = mkVec(159, 19, 7, 1, 1, 0, 0, 0, 1);
      vecs[15] = mkVec(160,  0, 0, 1, 1, 1, 1, 1, 2);

      $display("[TB] holding reset for 5 clocks");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1);
      checkOutput("reset A", 64'(actA), 64'(RESET_OBS));
      checkOutput("reset B", 64'(actB), 64'(RESET_OBS));

      $display("[TB] raster vectors");
      for (int i = 0; i < NUM_VECS; i++) begin
         while (curN < vecs[i].cycle) applyStimulus(1'b0);
         checkOutput($sformatf("vector %0d A", i), packObs(actA), packVec(vecs[i]));
         checkOutput($sformatf("vector %0d B", i), packObs(actB), packVec(vecs[i]));
      end

      // n=160: the A timer wraps exactly on this frame start.
      checkOutput("simultaneous tick A", 64'(ifA.anim_tick), 64'(1));
      checkOutput("phase after tick A", 64'(ifA.anim_phase), 64'(1));
      checkOutput("tick B frame 1", 64'(ifB.anim_tick), 64'(1));

      // One full frame of counting, bounded by two frame lengths.
      hsLow  = 0;
      vsLow  = 0;
      deHigh = 0;
      gap    = -1;
      for (int i = 1; i <= 2 * FRAME && gap < 0; i++) begin
         applyStimulus(1'b0);
         if (!ifA.hsync_n) hsLow++;
         if (!ifA.vsync_n) vsLow++;
         if (ifA.de) deHigh++;
         if (ifA.frame_start) gap = i;
      end
      checkOutput("frame_start spacing", 64'(gap), 64'(FRAME));
      checkOutput("hsync low clocks per frame", 64'(hsLow), 64'(4 * V_TOTAL));
      checkOutput("vsync low clocks per frame", 64'(vsLow), 64'(H_TOTAL));
      checkOutput("de high clocks per frame", 64'(deHigh), 64'(H_ACTIVE * V_ACTIVE));
      checkOutput("no stale pending tick A", 64'(ifA.anim_tick), 64'(1'b0));
      checkOutput("tick B frame 2", 64'(ifB.anim_tick), 64'(1));

      while (curN < 3 * FRAME) applyStimulus(1'b0);
      checkOutput("tick A frame 3", 64'(ifA.anim_tick), 64'(1));
      checkOutput("phase A frame 3", 64'(ifA.anim_phase), 64'(0));

      $display("[TB] reset in mid-frame at row 3 col 5");
      while (curN < 3 * FRAME + 3 * H_TOTAL + 5) applyStimulus(1'b0);
      checkOutput("mid-frame position", 64'({ifA.row, ifA.col}), 64'({11'd3, 11'd5}));
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("mid-frame reset A", 64'(actA), 64'(RESET_OBS));
      applyStimulus(1'b0);
      checkOutput("restart frame_start", 64'(ifA.frame_start), 64'(1));
      checkOutput("restart frame_cnt", 64'(ifA.frame_cnt), 64'(1));
      checkOutput("restart de_d A n=0", 64'({ifA.hsync_n_d, ifA.de_d}), 64'(2'b10));
      checkOutput("restart de_d B n=0", 64'(ifB.de_d), 64'(1));
      applyStimulus(1'b0);
      checkOutput("restart de_d A n=1", 64'({ifA.hsync_n_d, ifA.de_d}), 64'(2'b10));
      applyStimulus(1'b0);
      checkOutput("restart de_d A n=2", 64'(ifA.de_d), 64'(1));

      gap = -1;
      for (int i = 3; i <= 2 * FRAME && gap < 0; i++) begin
         applyStimulus(1'b0);
         if (ifA.frame_start) gap = i;
      end
      checkOutput("frame spacing after reset", 64'(gap), 64'(FRAME));
      checkOutput("frame_cnt after reset", 64'(ifA.frame_cnt), 64'(2));
      checkOutput("fresh tick interval A", 64'(ifA.anim_tick), 64'(1));

      @(negedge CLK);
      #1;
      checkOutput("scoreboard drained", 64'(qA.size() + qB.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator for the 50 MHz 1040×666-line display path. Produces the column/row scan position, active-low sync pulses, a data-enable flag, frame/line markers and a frame-aligned animation tick that replaces derived-clock animation timers. Sits directly upstream of the picture/pixel-colour stage, which consumes `col`/`row`/`anim_tick` and drives RGB. It also provides delayed sync copies aligned to that stage's registered RGB output.

## Interface
- `H_TOTAL`, 1040: clocks per line.
- `H_ACTIVE`, 900: visible columns, 0..H_ACTIVE-1.
- `H_SYNC_START`, 919: first column with hsync asserted.
- `H_SYNC_END`, 1039: first column after hsync (exclusive).
- `V_TOTAL`, 666: lines per frame.
- `V_ACTIVE`, 650: visible rows.
- `V_SYNC_START`, 659: first row with vsync asserted.
- `V_SYNC_END`, 665: first row after vsync (exclusive).
- `TICK_CYCLES`, 12_500_000: clocks between animation tick requests.
- `PIPE_DELAY`, 1: extra delay of `*_d` outputs in clocks, 0..8.
- `CLK` in 1: system/pixel clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `col` out 11: current column.
- `row` out 11: current row.
- `hsync_n` out 1: horizontal sync, active low.
- `vsync_n` out 1: vertical sync, active low.
- `de` out 1: pixel inside active area.
- `line_start` out 1: pulse, col==0.
- `frame_start` out 1: pulse, col==0 && row==0.
- `anim_tick` out 1: one-cycle animation step pulse, always coincident with `frame_start`.
- `anim_phase` out 1: toggles on every `anim_tick`.
- `frame_cnt` out 16: frames started since reset, wraps.
- `hsync_n_d`, `vsync_n_d`, `de_d` out 1 each: `hsync_n`/`vsync_n`/`de` delayed PIPE_DELAY clocks.

## Operation
- Internal counters `hc` 0..H_TOTAL-1 and `vc` 0..V_TOTAL-1.
  - `hc` increments each clock and wraps to 0 after H_TOTAL-1.
  - `vc` increments when `hc` wraps and wraps to 0 after V_TOTAL-1.
- Output decode is registered from one counter value, so all non-`_d` outputs are mutually aligned.
  - `hsync_n` = ~(H_SYNC_START ≤ hc < H_SYNC_END).
  - `vsync_n` = ~(V_SYNC_START ≤ vc < V_SYNC_END).
  - `de` = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- Tick counter `tc` 0..TICK_CYCLES-1 is free-running. On wrap it sets `pending`.
- At the next frame start, `anim_tick`=1 and `pending` clears.
  - A wrap in the same cycle as a frame start fires that frame.
  - Multiple wraps within one frame collapse to one tick.
- `anim_phase` toggles with each `anim_tick`.
- `frame_cnt` increments with each `frame_start` and wraps 0xFFFF→0.
- `_d` outputs come from a shift register of depth PIPE_DELAY. PIPE_DELAY=0 means a combinational pass-through of the registered outputs.
- Widths: `col`/`row` are zero-extended to 11 bits. Elaborate-time error if H_TOTAL or V_TOTAL > 2048, if sync end ≤ start, or if a sync window overlaps the active area. `tc` width is $clog2(TICK_CYCLES).

## Timing
- Reset values: `hc`=`vc`=`tc`=0, `pending`=0.
  - Outputs: `col`=`row`=0, `hsync_n`=1, `vsync_n`=1, `de`=0, `line_start`=`frame_start`=`anim_tick`=0, `anim_phase`=0, `frame_cnt`=0.
  - All `_d` stages reset to 1/1/0.
- First clock after `rst` falls: counters at 0. Outputs then show `col`=0, `row`=0, `de`=1, `line_start`=1, `frame_start`=1, `frame_cnt` 0→1.
- Latency:
  - counter → outputs: 1 clock.
  - outputs → `_d` outputs: PIPE_DELAY clocks.
- Period between `frame_start` pulses: H_TOTAL×V_TOTAL = 692_640 clocks.
- `rst` mid-frame: everything returns to reset values the next edge, and the raster restarts at (0,0). A partial tick interval is discarded.
- Simultaneous tick wrap and frame start: `anim_tick` asserts that frame and `pending` stays 0.

## Structure
- Shared package `vga_timing_pkg` holds the default timing constants (H/V totals, active sizes, sync windows) and the coordinate width (11). The picture stage imports the same package for its active-area bounds.
- One sub-module: `sync_delay_line`, a parameterised-depth, resettable shift register of a 3-bit bus with per-bit reset value.

## Test plan
- Reset: hold `rst` 5 clocks → all outputs at the reset values above. Release → next output cycle shows `col`=0, `row`=0, `frame_start`=1, `de`=1.
- Line wrap: `col` goes 1039→0 with `row` 0→1 and `line_start`=1. `hsync_n` is low for exactly 120 clocks at `col` 919..1038.
- Frame: `row` goes 665→0 with `frame_start`=1. `vsync_n` is low for rows 659..664 (6×1040 clocks). `de` high for 585_000 clocks per frame. `frame_start` spacing is 692_640.
- Anim tick with TICK_CYCLES=1000: `anim_tick` fires only on `frame_start`, once per frame, and `anim_phase` alternates. With TICK_CYCLES=2_000_000, a tick occurs every 3rd or 2nd frame per the `pending` rule.
- Reset mid-frame at `row`=300, `col`=500: the next frame start comes 692_640 clocks after release + 1. `frame_cnt` restarts at 1.
- PIPE_DELAY=0 and PIPE_DELAY=2: `de_d`/`hsync_n_d` equal `de`/`hsync_n` shifted by 0 and 2 clocks, and read their reset values during the first 2 clocks.
